// File: rtl/mm_drv_pkg.sv
// -----------------------------------------------------------------------------
// mm_drv_pkg
// Shared definitions for the Wishbone driver of the 2x2 8-bit matrix-multiply
// engine: register offsets (word index, wbs_adr_i[4:2]), CTRL/STATUS bit
// positions, the sequencer state type and the operand-byte selector.
// -----------------------------------------------------------------------------
package mm_drv_pkg;

  localparam int LOAD_CYCLES = 8;
  localparam int RES_W       = 17;

  localparam logic [2:0] OFS_OPA    = 3'd0;
  localparam logic [2:0] OFS_OPB    = 3'd1;
  localparam logic [2:0] OFS_CTRL   = 3'd2;
  localparam logic [2:0] OFS_STATUS = 3'd3;
  localparam logic [2:0] OFS_RES0   = 3'd4;
  localparam logic [2:0] OFS_RES1   = 3'd5;
  localparam logic [2:0] OFS_RES2   = 3'd6;
  localparam logic [2:0] OFS_RES3   = 3'd7;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_SRST_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAP  = 2'd2
  } state_e;

  // Load index k selects A00..A11 (k = 0..3) then B00..B11 (k = 4..7),
  // which is simply byte k of the concatenation {OPB, OPA}.
  function automatic logic [7:0] operand_byte(input logic [31:0] opa,
                                              input logic [31:0] opb,
                                              input logic [2:0]  k);
    logic [63:0] ops;
    ops = {opb, opa};
    return ops[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mm_drv_seq.sv
// -----------------------------------------------------------------------------
// mm_drv_seq
// Sequencer for the matrix-multiply engine pin protocol. From IDLE an accepted
// start walks the eight operand bytes onto mm_sel_in/mm_input_val with
// execute low, then steps mm_sel_out through C00..C11 with execute high,
// holding each index SETTLE_CYCLES cycles and requesting a capture on the
// last one. abort_i returns to IDLE and pulses the engine reset for a cycle.
//
// Ports:
//   clk_i, srst_i        clock, synchronous active-high reset
//   start_i, abort_i     run request (ignored unless IDLE), abort (wins)
//   opa_i, opb_i         operand words, byte k = operand k
//   mm_*_o               registered engine pins
//   busy_o               sequencer not IDLE
//   done_pulse_o         one cycle, coincides with the final capture
//   res_we_o, res_idx_o  capture mm_result into RES[res_idx_o] at this edge
// -----------------------------------------------------------------------------
module mm_drv_seq
  import mm_drv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        mm_reset_n_o,
  output logic        mm_execute_o,
  output logic [2:0]  mm_sel_in_o,
  output logic [7:0]  mm_input_val_o,
  output logic [1:0]  mm_sel_out_o,
  output logic        busy_o,
  output logic        done_pulse_o,
  output logic        res_we_o,
  output logic [1:0]  res_idx_o
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LOAD_LAST   = 3'(LOAD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;        // load index
  logic [1:0] j_q, j_d;        // result index
  logic [3:0] s_q, s_d;        // settle counter within one result index

  logic       reset_n_q;
  logic       execute_q;
  logic [2:0] sel_in_q;
  logic [7:0] val_q;
  logic [1:0] sel_out_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    s_d          = s_q;
    res_we_o     = 1'b0;
    done_pulse_o = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      k_d     = '0;
      j_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD;
            k_d     = '0;
          end
        end
        LOAD: begin
          if (k_q == LOAD_LAST) begin
            state_d = CAP;
            j_d     = '0;
            s_d     = '0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        CAP: begin
          if (s_q == SETTLE_LAST) begin
            res_we_o = 1'b1;
            s_d      = '0;
            if (j_q == 2'd3) begin
              state_d      = IDLE;
              done_pulse_o = 1'b1;
            end else begin
              j_d = j_q + 2'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pin registers are loaded from the next-state values so that the engine
  // sees LOAD index 0 in the very first cycle after the start is sampled.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      j_q       <= '0;
      s_q       <= '0;
      reset_n_q <= 1'b0;
      execute_q <= 1'b1;
      sel_in_q  <= '0;
      val_q     <= '0;
      sel_out_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      s_q       <= s_d;
      reset_n_q <= ~abort_i;
      execute_q <= (state_d != LOAD);
      sel_in_q  <= (state_d == LOAD) ? k_d : 3'd0;
      val_q     <= (state_d == LOAD) ? operand_byte(opa_i, opb_i, k_d) : 8'd0;
      sel_out_q <= (state_d == CAP) ? j_d : 2'd0;
    end
  end

  assign mm_reset_n_o   = reset_n_q;
  assign mm_execute_o   = execute_q;
  assign mm_sel_in_o    = sel_in_q;
  assign mm_input_val_o = val_q;
  assign mm_sel_out_o   = sel_out_q;
  assign busy_o         = (state_q != IDLE);
  assign res_idx_o      = j_q;

endmodule

// File: rtl/mm_wb_driver.sv
// -----------------------------------------------------------------------------
// mm_wb_driver
// Wishbone slave that lets firmware load A/B operands into the 2x2 8-bit
// matrix-multiply engine, run it, and read back the four 17-bit products.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone request
//   wbs_adr_i, wbs_dat_i        address (word offset in [4:2]), write data
//   wbs_ack_o, wbs_dat_o        one-cycle ack, registered read data
//   mm_reset_n .. mm_sel_out    registered engine pins
//   mm_result                   engine product (combinational in sel_out)
//   irq_o                       done & irq_en, level
// Registers: OPA, OPB, CTRL{irq_en,soft_reset,start}, STATUS{done,busy},
//            RES0..RES3.
// -----------------------------------------------------------------------------
module mm_wb_driver
  import mm_drv_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE     = 32'h3000_0000,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             mm_reset_n,
  output logic             mm_execute,
  output logic [2:0]       mm_sel_in,
  output logic [7:0]       mm_input_val,
  output logic [1:0]       mm_sel_out,
  input  logic [RES_W-1:0] mm_result,
  output logic             irq_o
);

  logic             ack_q;
  logic [31:0]      dat_q, rdata_d;
  logic [31:0]      opa_q, opa_d, opb_q, opb_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] res_q [4];
  logic [RES_W-1:0] res_d [4];

  logic       req_valid, req_accept, wr_accept;
  logic [2:0] ofs;
  logic       ctrl_wr, start_req, abort, start_acc, done_clr;
  logic       opa_wr, opb_wr;
  logic       busy, done_pulse, res_we;
  logic [1:0] res_idx;
  logic       unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  // A request is not accepted in the ack cycle itself, so a held request
  // is acknowledged every other cycle and each access has a single effect.
  assign req_valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
  assign req_accept = req_valid & ~ack_q;
  assign wr_accept  = req_accept & wbs_we_i;
  assign ofs        = wbs_adr_i[4:2];

  assign ctrl_wr   = wr_accept & (ofs == OFS_CTRL) & wbs_sel_i[0];
  assign start_req = ctrl_wr & wbs_dat_i[CTRL_START_BIT];
  assign abort     = ctrl_wr & wbs_dat_i[CTRL_SRST_BIT];
  assign start_acc = start_req & ~abort & ~busy;
  assign done_clr  = wr_accept & (ofs == OFS_STATUS) & wbs_sel_i[0]
                   & wbs_dat_i[STAT_DONE_BIT];

  // Operands are frozen while the sequencer is reading them.
  assign opa_wr = wr_accept & (ofs == OFS_OPA) & ~busy;
  assign opb_wr = wr_accept & (ofs == OFS_OPB) & ~busy;

  for (genvar gi = 0; gi < 4; gi++) begin : g_opbyte
    assign opa_d[gi*8 +: 8] = (opa_wr & wbs_sel_i[gi]) ? wbs_dat_i[gi*8 +: 8] : opa_q[gi*8 +: 8];
    assign opb_d[gi*8 +: 8] = (opb_wr & wbs_sel_i[gi]) ? wbs_dat_i[gi*8 +: 8] : opb_q[gi*8 +: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_res
    assign res_d[gi] = (res_we && (res_idx == 2'(gi))) ? mm_result : res_q[gi];
  end

  assign irq_en_d = ctrl_wr ? wbs_dat_i[CTRL_IRQEN_BIT] : irq_en_q;

  // A fresh start clears a stale done; completion beats a simultaneous clear.
  always_comb begin
    done_d = done_q;
    if (start_acc)       done_d = 1'b0;
    else if (done_pulse) done_d = 1'b1;
    else if (done_clr)   done_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    case (ofs)
      OFS_OPA:    rdata_d = opa_q;
      OFS_OPB:    rdata_d = opb_q;
      OFS_CTRL:   rdata_d[CTRL_IRQEN_BIT] = irq_en_q;
      OFS_STATUS: begin
        rdata_d[STAT_BUSY_BIT] = busy;
        rdata_d[STAT_DONE_BIT] = done_q;
      end
      default:    rdata_d[RES_W-1:0] = res_q[ofs[1:0]];
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      for (int n = 0; n < 4; n++) res_q[n] <= '0;
    end else begin
      ack_q    <= req_accept;
      dat_q    <= (req_accept & ~wbs_we_i) ? rdata_d : 32'd0;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      for (int n = 0; n < 4; n++) res_q[n] <= res_d[n];
    end
  end

  mm_drv_seq #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_seq (
    .clk_i         (wb_clk_i),
    .srst_i        (wb_rst_i),
    .start_i       (start_acc),
    .abort_i       (abort),
    .opa_i         (opa_q),
    .opb_i         (opb_q),
    .mm_reset_n_o  (mm_reset_n),
    .mm_execute_o  (mm_execute),
    .mm_sel_in_o   (mm_sel_in),
    .mm_input_val_o(mm_input_val),
    .mm_sel_out_o  (mm_sel_out),
    .busy_o        (busy),
    .done_pulse_o  (done_pulse),
    .res_we_o      (res_we),
    .res_idx_o     (res_idx)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = done_q & irq_en_q;

endmodule

// File: tb/tb_mm_wb_driver.sv
// -----------------------------------------------------------------------------
// tb_mm_wb_driver
// Two driver instances (SETTLE_CYCLES = 1 and 3), each connected to a small
// behavioural model of the matrix-multiply engine. Reads push their expected
// value into a queue; a monitor pops and compares on every read ack. Engine
// load cycles of instance 0 are checked the same way against a load queue.
// -----------------------------------------------------------------------------
module tb_mm_wb_driver;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, cyc, stb, we, ack, rstn, exe, irq;
  logic [1:0][3:0]   sel;
  logic [1:0][31:0]  adr, wdat, rdat;
  logic [1:0][2:0]   sel_in;
  logic [1:0][7:0]   ival;
  logic [1:0][1:0]   sel_out;
  logic [1:0][16:0]  res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_exp  [$];
  string       q_name [$];
  int          q_inst [$];
  logic [10:0] load_q [$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [7:0] ea [4];
    logic [7:0] eb [4];

    // Engine model: operands latched while execute is low, C = A x B.
    always @(posedge clk) begin
      if (rstn[gi] === 1'b0) begin
        for (int k = 0; k < 4; k++) begin
          ea[k] <= 8'd0;
          eb[k] <= 8'd0;
        end
      end else if (exe[gi] === 1'b0) begin
        if (sel_in[gi][2]) eb[sel_in[gi][1:0]] <= ival[gi];
        else               ea[sel_in[gi][1:0]] <= ival[gi];
      end
    end

    assign res[gi] = exe[gi] ?
      (17'(ea[{sel_out[gi][1], 1'b0}]) * 17'(eb[{1'b0, sel_out[gi][0]}]) +
       17'(ea[{sel_out[gi][1], 1'b1}]) * 17'(eb[{1'b1, sel_out[gi][0]}])) : 17'd0;

    mm_wb_driver #(
      .ADDR_BASE    (BASE),
      .SETTLE_CYCLES(gi == 0 ? 1 : 3)
    ) u_dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst[gi]),
      .wbs_stb_i   (stb[gi]),
      .wbs_cyc_i   (cyc[gi]),
      .wbs_we_i    (we[gi]),
      .wbs_sel_i   (sel[gi]),
      .wbs_adr_i   (adr[gi]),
      .wbs_dat_i   (wdat[gi]),
      .wbs_ack_o   (ack[gi]),
      .wbs_dat_o   (rdat[gi]),
      .mm_reset_n  (rstn[gi]),
      .mm_execute  (exe[gi]),
      .mm_sel_in   (sel_in[gi]),
      .mm_input_val(ival[gi]),
      .mm_sel_out  (sel_out[gi]),
      .mm_result   (res[gi]),
      .irq_o       (irq[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone access; waits a bounded number of cycles for the ack.
  task automatic xfer(input int i, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output bit got);
    @(posedge clk); #1;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; adr[i] = a; wdat[i] = d;
    got = 1'b0;
    for (int n = 0; n < 3 && !got; n++) begin
      @(posedge clk); #1;
      got = (ack[i] === 1'b1);
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [2:0] ofs, input logic [31:0] d,
                    input logic [3:0] s = 4'hF);
    bit got;
    xfer(i, 1'b1, BASE | {27'd0, ofs, 2'b00}, d, s, got);
    $display("wr inst%0d ofs%0d sel=%b data=0x%08h ack=%0d", i, ofs, s, d, got);
    chk("wr_ack", 32'(got), 32'd1);
  endtask

  task automatic rd(input int i, input logic [2:0] ofs, input logic [31:0] exp,
                    input string name);
    bit got;
    q_exp.push_back(exp); q_name.push_back(name); q_inst.push_back(i);
    xfer(i, 1'b0, BASE | {27'd0, ofs, 2'b00}, 32'd0, 4'hF, got);
    chk({name, "_ack"}, 32'(got), 32'd1);
    if (!got) begin
      void'(q_exp.pop_back()); void'(q_name.pop_back()); void'(q_inst.pop_back());
    end
  endtask

  task automatic push_loads(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] w;
      w = (k < 4) ? a : b;
      load_q.push_back({3'(k), w[(k % 4) * 8 +: 8]});
    end
  endtask

  // Called right after the start write returns (cycle 1 after E0). Counts
  // edges after E0 until irq_o is seen and checks the readout pins on the way.
  task automatic run_timed(input int i, input int s, input int exp_edges);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (edges >= 8 && edges < 8 + 4 * s) begin
        chk("cap_execute", 32'(exe[i]), 32'd1);
        chk("cap_sel_out", 32'(sel_out[i]), 32'((edges - 8) / s));
      end
      seen = (irq[i] === 1'b1);
    end
    chk("done_latency", 32'(edges), 32'(exp_edges));
  endtask

  // Scoreboard monitor: read data on every read ack, load pins while execute low.
  string       m_name;
  logic [31:0] m_exp;
  int          m_inst;
  logic [10:0] m_load;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack[i] === 1'b1 && we[i] === 1'b0) begin
        if (q_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: inst%0d got 0x%08h, expected no read", i, rdat[i]);
        end else begin
          m_exp = q_exp.pop_front(); m_name = q_name.pop_front(); m_inst = q_inst.pop_front();
          $display("rd inst%0d %s = 0x%08h (expect 0x%08h)", i, m_name, rdat[i], m_exp);
          chk({m_name, "_inst"}, 32'(i), 32'(m_inst));
          chk(m_name, rdat[i], m_exp);
        end
      end
    end
    if (exe[0] === 1'b0) begin
      if (load_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL load_extra: execute low with sel_in=%0d val=0x%02h, expected no load",
                 sel_in[0], ival[0]);
      end else begin
        m_load = load_q.pop_front();
        chk("load_pins", {21'd0, sel_in[0], ival[0]}, {21'd0, m_load});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 2'b11; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack",     32'(ack[i]),     32'd0);
      chk("rst_dat",     rdat[i],         32'd0);
      chk("rst_reset_n", 32'(rstn[i]),    32'd0);
      chk("rst_execute", 32'(exe[i]),     32'd1);
      chk("rst_sel_in",  32'(sel_in[i]),  32'd0);
      chk("rst_val",     32'(ival[i]),    32'd0);
      chk("rst_sel_out", 32'(sel_out[i]), 32'd0);
      chk("rst_irq",     32'(irq[i]),     32'd0);
    end
    rst = 2'b00;
    @(posedge clk); #1;
    chk("reset_n_release", 32'(rstn[0]), 32'd1);
    rd(0, 3'd3, 32'd0, "status_rst");
    rd(0, 3'd2, 32'd0, "ctrl_rst");
    rd(0, 3'd4, 32'd0, "res0_rst");
    rd(0, 3'd0, 32'd0, "opa_rst");
    xfer(0, 1'b0, BASE | 32'h20, 32'd0, 4'hF, got);
    chk("addr_miss_no_ack", 32'(got), 32'd0);

    // Basic multiply, SETTLE_CYCLES = 1
    wr(0, 3'd0, 32'h0403_0201);
    wr(0, 3'd1, 32'h0807_0605);
    wr(0, 3'd2, 32'h0000_0004);
    rd(0, 3'd2, 32'h0000_0004, "ctrl_irq_en");
    push_loads(32'h0403_0201, 32'h0807_0605);
    wr(0, 3'd2, 32'h0000_0005);
    run_timed(0, 1, 12);
    rd(0, 3'd3, 32'h2, "status_done");
    rd(0, 3'd4, 32'd19, "basic_res0");
    rd(0, 3'd5, 32'd22, "basic_res1");
    rd(0, 3'd6, 32'd43, "basic_res2");
    rd(0, 3'd7, 32'd50, "basic_res3");
    rd(0, 3'd2, 32'h4, "ctrl_start_reads0");

    // Interrupt clear
    chk("irq_high", 32'(irq[0]), 32'd1);
    wr(0, 3'd3, 32'h2);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq[0]), 32'd0);
    rd(0, 3'd3, 32'h0, "status_cleared");

    // Max operands
    wr(0, 3'd0, 32'hFFFF_FFFF);
    wr(0, 3'd1, 32'hFFFF_FFFF);
    push_loads(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(0, 3'd2, 32'h5);
    run_timed(0, 1, 12);
    rd(0, 3'd4, 32'h1FC02, "max_res0");
    rd(0, 3'd5, 32'h1FC02, "max_res1");
    rd(0, 3'd6, 32'h1FC02, "max_res2");
    rd(0, 3'd7, 32'h1FC02, "max_res3");
    chk("load_count", 32'(load_q.size()), 32'd0);

    // Byte enables, writes and start while busy
    wr(0, 3'd0, 32'h0);
    wr(0, 3'd0, 32'hFFFF_FFFF, 4'b0010);
    rd(0, 3'd0, 32'h0000_FF00, "opa_byte_en");
    wr(0, 3'd1, 32'h0403_0201);
    push_loads(32'h0000_FF00, 32'h0403_0201);
    wr(0, 3'd2, 32'h5);
    wr(0, 3'd1, 32'hAAAA_AAAA);
    rd(0, 3'd1, 32'h0403_0201, "opb_busy_ignored");
    wr(0, 3'd2, 32'h5);
    rd(0, 3'd3, 32'h1, "status_busy");
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #1;
      got = (irq[0] === 1'b1);
    end
    chk("be_run_done", 32'(got), 32'd1);
    rd(0, 3'd4, 32'd765,  "be_res0");
    rd(0, 3'd5, 32'd1020, "be_res1");
    rd(0, 3'd6, 32'd0,    "be_res2");
    rd(0, 3'd7, 32'd0,    "be_res3");
    repeat (20) @(posedge clk);
    rd(0, 3'd3, 32'h2, "no_second_run");

    // soft_reset in LOAD cycle 5
    push_loads(32'h0000_FF00, 32'h0403_0201);
    wr(0, 3'd2, 32'h5);
    repeat (3) @(posedge clk);
    wr(0, 3'd2, 32'h6);
    chk("srst_reset_n_low", 32'(rstn[0]), 32'd0);
    chk("srst_execute",     32'(exe[0]),  32'd1);
    chk("srst_loads_left",  32'(load_q.size()), 32'd3);
    load_q.delete();
    @(posedge clk); #1;
    chk("srst_reset_n_high", 32'(rstn[0]), 32'd1);
    rd(0, 3'd3, 32'h0,    "srst_status");
    rd(0, 3'd4, 32'd765,  "srst_res0");
    rd(0, 3'd5, 32'd1020, "srst_res1");
    rd(0, 3'd6, 32'd0,    "srst_res2");
    rd(0, 3'd7, 32'd0,    "srst_res3");

    // soft_reset together with start: no run
    wr(0, 3'd2, 32'h7);
    repeat (15) @(posedge clk);
    rd(0, 3'd3, 32'h0, "srst_start_status");

    // wb_rst_i during CAP
    push_loads(32'h0000_FF00, 32'h0403_0201);
    wr(0, 3'd2, 32'h5);
    repeat (10) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("wbrst_execute", 32'(exe[0]),  32'd1);
    chk("wbrst_reset_n", 32'(rstn[0]), 32'd0);
    rst[0] = 1'b0;
    rd(0, 3'd4, 32'd0, "wbrst_res0");
    rd(0, 3'd5, 32'd0, "wbrst_res1");
    rd(0, 3'd6, 32'd0, "wbrst_res2");
    rd(0, 3'd7, 32'd0, "wbrst_res3");
    rd(0, 3'd2, 32'd0, "wbrst_ctrl");
    chk("wbrst_irq", 32'(irq[0]), 32'd0);

    // SETTLE_CYCLES = 3
    wr(1, 3'd0, 32'h0403_0201);
    wr(1, 3'd1, 32'h0807_0605);
    wr(1, 3'd2, 32'h5);
    run_timed(1, 3, 20);
    rd(1, 3'd4, 32'd19, "s3_res0");
    rd(1, 3'd5, 32'd22, "s3_res1");
    rd(1, 3'd6, 32'd43, "s3_res2");
    rd(1, 3'd7, 32'd50, "s3_res3");
    rd(1, 3'd3, 32'h2,  "s3_status");

    repeat (2) @(posedge clk);
    chk("read_queue_drained", 32'(q_exp.size()), 32'd0);
    chk("load_queue_drained", 32'(load_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_wb_driver.md
# mm_wb_driver

Wishbone-slave initiator that drives the pin-level interface of the 2x2 8-bit matrix-multiply engine from the management SoC. Firmware writes the A and B operands and a start bit. The block sequences the engine's load protocol (sel_in / input_val / execute low), then its readout protocol (execute high, sel_out stepping), and captures the four 17-bit products into readable registers. It sits in the user project between the WB MI A port and the engine's port signals.

## Interface
Parameters:
- ADDR_BASE, 32'h3000_0000: block responds when wbs_adr_i[31:5] == ADDR_BASE[31:5].
- SETTLE_CYCLES, 1: cycles each sel_out value is held before the result is sampled (range 1..15).

Ports:
- wb_clk_i  in  1  the single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- mm_reset_n  out  1  engine reset, active low.
- mm_execute  out  1  engine execute. 0 = load phase, 1 = readout.
- mm_sel_in  out  3  operand index. 0..3 = A00, A01, A10, A11; 4..7 = B00, B01, B10, B11.
- mm_input_val  out  8  operand byte.
- mm_sel_out  out  2  result index: C00, C01, C10, C11.
- mm_result  in  17  engine result. Combinational in sel_out and execute.
- irq_o  out  1  done interrupt, level.

## Operation
- Register map, at offset wbs_adr_i[4:2]:
  - 0 OPA: bytes A00[7:0], A01[15:8], A10[23:16], A11[31:24].
  - 1 OPB: same byte layout for B.
  - 2 CTRL: bit0 start (write-1, reads 0); bit1 soft_reset (write-1, reads 0); bit2 irq_en (R/W).
  - 3 STATUS: bit0 busy; bit1 done (sticky, write-1-to-clear).
  - 4..7 RES0..RES3: C00, C01, C10, C11 in bits [16:0]; bits [31:17] read 0.
- OPA and OPB honour wbs_sel_i per byte. CTRL and STATUS act only when wbs_sel_i[0] = 1.
- Writes to OPA/OPB while busy are acked and ignored. A start while busy is ignored.
- States:
  - IDLE: mm_execute = 1, which keeps the engine's load decoder disabled.
  - LOAD: 8 cycles, index k = 0..7. mm_execute = 0, mm_sel_in = k, mm_input_val = operand byte k.
  - CAP: 4 × SETTLE_CYCLES cycles. mm_execute = 1, mm_sel_out = j. mm_result is sampled into RESj at the end of the last settle cycle of index j.
  - Then the block returns to IDLE, sets done, and clears busy.
- Transitions:
  - IDLE → LOAD on an accepted start. The same start clears done.
  - soft_reset in any state: abort to IDLE, pulse mm_reset_n low for 1 cycle. OPA, OPB and RES are kept; done is not set.
- irq_o = done & irq_en.
- Arithmetic: the block does none. Maximum result is 2·255² = 130050 (0x1FC02), which fits in 17 bits. Results are captured unmodified.

## Timing
- Reset values:
  - Outputs: wbs_ack_o 0, wbs_dat_o 0, mm_reset_n 0 (while wb_rst_i is high, then 1), mm_execute 1, mm_sel_in 0, mm_input_val 0, mm_sel_out 0, irq_o 0.
  - Registers: all cleared, irq_en 0, state IDLE.
- Wishbone handshake:
  - A request is valid = cyc & stb & address match.
  - It is sampled at edge E. ack is high for exactly the cycle after E; write effects are applied at E.
  - ack is forced low in the cycle after an ack, so a held request is acked every other cycle.
  - Read data is registered and valid while ack is high.
- Start latency:
  - A start write sampled at edge E0 drives LOAD in cycles 1..8 after E0.
  - CAP runs in cycles 9 .. 8 + 4·SETTLE_CYCLES.
  - busy = 1 from E0. done = 1 and busy = 0 at the end of the last CAP cycle, so with SETTLE_CYCLES = 1, done is first readable in cycle 13.
- All engine outputs are registered (no glitches on the pads).
- Simultaneous events:
  - A start and a done-clear in the same cycle: start wins, done = 0.
  - wb_rst_i overrides everything.
  - soft_reset together with start: reset wins, no run.
- Reset mid-LOAD or mid-CAP (wb_rst_i or soft_reset): the engine is reset, and the RES registers hold their previous values, except that wb_rst_i clears them.

## Structure
- Package mm_drv_pkg holds:
  - register offsets (OFS_OPA .. OFS_RES3);
  - CTRL and STATUS bit positions;
  - the state enum (IDLE, LOAD, CAP);
  - LOAD_CYCLES = 8 and RES_W = 17.
- One sub-module, mm_drv_seq: the FSM plus the load and capture counters. It takes start/abort and the operand words, drives the mm_* outputs, and returns busy, done_pulse, res_we and res_idx. The top level holds the Wishbone decode and the register file.

## Test plan
- Basic multiply. Stimulus: OPA = 0x04030201, OPB = 0x08070605, start. Response: RES0..3 = 19, 22, 43, 50; done = 1; busy 12 cycles for SETTLE_CYCLES = 1.
- Max operands. Stimulus: all bytes 0xFF, start. Response: every RES = 0x1FC02. Check the mm_sel_in sequence is 0..7 with mm_execute low for exactly 8 cycles.
- Byte enables and busy. Stimulus: write OPA = 0xFFFFFFFF with sel = 4'b0010 → OPA reads 0x0000FF00. Then write OPB while busy → OPB unchanged, the write is acked. Then a start while busy → no second run.
- Interrupt. Stimulus: irq_en = 1, run to completion. Response: irq_o rises with done; writing STATUS = 0x2 drops it the cycle after the ack.
- Mid-operation reset. Stimulus: soft_reset in LOAD cycle 5. Response: mm_reset_n low for 1 cycle, state IDLE, done = 0, RES registers unchanged. Then wb_rst_i during CAP → all RES registers = 0, mm_execute = 1.
- SETTLE_CYCLES = 3. Response: each mm_sel_out value is held 3 cycles, done arrives 20 cycles after E0, and results are correct.
